// File: rtl/ser_pkg.sv
// Shared definitions for the serial link: default word width, minimum legal
// bit count and the transmitter FSM state type.
package ser_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MIN_MOD    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter feeding the 16-bit deserializer.
// A request captures a word and a bit count; the selected bits then leave one
// per clock on ser_data_o/ser_data_val_o while busy_o holds off the source.
// Optional build macro: WORD_SERIALIZER_LSB_FIRST_EN selects LSB-first order
// (default is MSB-first).
module word_serializer
  import ser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  // One extra bit so a full DATA_W count fits without wrapping.
  localparam int CNT_W = MOD_W + 1;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] shreg_r, shreg_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [CNT_W-1:0]  len_s;
  logic              mod_ok_s;
  logic              accept_s;
  logic              ser_data_r, ser_data_s;
  logic              ser_val_r, ser_val_s;
  logic              busy_r, busy_s;

  // Bit that leaves the word next.
  function automatic logic tap_bit(input logic [DATA_W-1:0] w);
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  // Word after the tapped bit has been consumed.
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    return {1'b0, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], 1'b0};
`endif
  endfunction

  // Decode the requested length; counts 1 and 2 are rejected, 0 means a full word.
  always_comb begin
    len_s    = {1'b0, data_mod_i};
    mod_ok_s = 1'b0;
    if (data_mod_i == {MOD_W{1'b0}}) begin
      len_s    = CNT_W'(DATA_W);
      mod_ok_s = 1'b1;
    end else begin
      mod_ok_s = ({1'b0, data_mod_i} >= CNT_W'(MIN_MOD));
    end
    accept_s = data_val_i & ~busy_r & mod_ok_s;
  end

  // Next-state and next-output logic; the first bit is driven straight from
  // data_i so it appears in the cycle right after acceptance.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    cnt_s      = cnt_r;
    ser_data_s = 1'b0;
    ser_val_s  = 1'b0;
    busy_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s    = SEND;
          ser_data_s = tap_bit(data_i);
          shreg_s    = shift_word(data_i);
          cnt_s      = len_s - CNT_W'(1);
          ser_val_s  = 1'b1;
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        // cnt_r counts bits still to drive after the one currently on the line.
        if (cnt_r != {CNT_W{1'b0}}) begin
          ser_data_s = tap_bit(shreg_r);
          shreg_s    = shift_word(shreg_r);
          cnt_s      = cnt_r - CNT_W'(1);
          ser_val_s  = 1'b1;
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_r    <= IDLE;
      shreg_r    <= {DATA_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      ser_data_r <= 1'b0;
      ser_val_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      cnt_r      <= cnt_s;
      ser_data_r <= ser_data_s;
      ser_val_r  <= ser_val_s;
      busy_r     <= busy_s;
    end
  end

  assign ser_data_o     = ser_data_r;
  assign ser_data_val_o = ser_val_r;
  assign busy_o         = busy_r;

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial converter that sits directly upstream of the 16-bit deserializer.
- Accepts one parallel word plus a bit count, then emits the selected bits one per clock on a serial data/valid pair that drives the deserializer's serial inputs.
- A registered busy flag provides backpressure to the word source.

Parameters:
- DATA_W, 16, parallel word width; must be a power of two, at least 4.
- MOD_W, $clog2(DATA_W), width of the bit-count input.

Ports:
- clk_i  input  1  system clock.
- srst_n_i  input  1  reset; synchronous, active-low.
- data_i  input  DATA_W  parallel word to transmit.
- data_mod_i  input  MOD_W  number of bits to send; 0 means DATA_W bits.
- data_val_i  input  1  request strobe; data_i and data_mod_i are valid in this cycle.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o is valid in this cycle.
- busy_o  output  1  high while a word is being transmitted; requests are dropped while high.

Behaviour:
- Reset: while srst_n_i=0 at a rising edge, all outputs and internal state clear next cycle (ser_data_o=0, ser_data_val_o=0, busy_o=0, FSM=IDLE). Reset mid-word abandons the word; no further bits are sent. A data_val_i sampled in a reset cycle is ignored.
- Bit count: len = DATA_W when data_mod_i=0, otherwise len = data_mod_i.
- Invalid count: data_mod_i=1 or 2 is invalid. The request is ignored, busy_o stays 0 and nothing is sent.
- Acceptance: a request is accepted at edge N when data_val_i=1, busy_o=0, srst_n_i=1 and the count is valid. data_i and len are captured into a shift register and a down-counter.
- FSM states:
  - IDLE -> SEND on accept.
  - SEND -> IDLE after the last bit is driven.
- Output timing: bits appear in cycles N+1 .. N+len with ser_data_val_o=1. busy_o=1 over exactly the same cycles.
- Bit order: MSB-first, data_i[DATA_W-1] first, then descending; the last bit is data_i[DATA_W-len]. Unsent low bits are discarded.
- Idle outputs: whenever ser_data_val_o=0, ser_data_o=0.
- Dropped requests: data_val_i sampled while busy_o=1 is dropped silently. Input changes during SEND have no effect.
- Back-to-back: busy_o=0 in cycle N+len+1, so the earliest next accept is that edge and its first bit appears in N+len+2. The serial stream therefore has exactly one idle cycle between words.
- Counter: the down-counter is MOD_W+1 bits wide so DATA_W is representable; no wrap-around.

Optional Feature:
- Macro: WORD_SERIALIZER_LSB_FIRST_EN.
- Defined: bit order is LSB-first; sent bits are data_i[0] .. data_i[len-1] and the upper bits are discarded. Timing and handshake are unchanged.
- Undefined (default): MSB-first as above.
- This is a single compile-time mux on the shift direction and the tap bit.

Decomposition:
- Shared package ser_pkg holds:
  - DATA_W_DEF = 16.
  - MIN_MOD = 3.
  - The FSM state enum state_t {IDLE, SEND}, shared with the deserializer bench.
- No sub-module; the shifter, counter and FSM live in one module.

Test Plan:
- Reset check: hold srst_n_i=0 for 3 cycles with data_val_i=1 -> all outputs stay 0 and nothing is sent.
- Full word: data_i=16'hA5C3, mod=0 -> 16 bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 in cycles N+1..N+16, with busy_o=1 over the same window. Repeat with the WORD_SERIALIZER_LSB_FIRST_EN build -> reversed order.
- Partial word and invalid counts: data_i=16'hF000, mod=5 -> bits 1,1,1,1,0 and then idle. mod=1 and mod=2 -> no ser_data_val_o and busy_o stays 0. mod=3 -> exactly 3 bits.
- Busy drop and back-to-back: during a 16-bit send, pulse data_val_i with 16'hFFFF -> dropped. Then request at the first busy_o=0 cycle -> a single idle gap between words.
- Reset mid-word: assert srst_n_i=0 at bit 7 of 16 -> next cycle ser_data_val_o=0 and busy_o=0; a new request after reset is sent in full.
- Loopback: connect to the deserializer and send 1000 random full 16-bit words -> deser_data_o[0:15] equals data_i[15:0] bit-for-bit, with one deser_data_val_o per word.
